waterfall_scroller: RTL and testbench
=====================================

# waterfall_scroller

Parametrised scrolling-spectrogram frame-buffer controller. It sits between the frequency-bin BRAM (filled by the SDFT), the single-port frame buffer RAM and the LCD `video` timing block. During active video it generates frame-buffer read addresses with a circular row offset. In lower blanking it copies one spectrum line into the buffer. It adds a runtime scroll rate, a freeze control, a selectable scroll direction and overrun detection.

## Interface
Parameters:
- `H_VISIBLE`, 320, pixels per line.
- `V_VISIBLE`, 240, lines per frame.
- `BINS`, 320, bins copied per line; must be ≤ `H_VISIBLE`.
- `PIX_W`, 8, pixel/bin data width.
- `X_W`, 9, width of x.
- `Y_W`, 8, width of y.
- `FB_ADDR_W`, 17, frame buffer address width; must satisfy ≥ clog2(H·V).
- `BIN_ADDR_W`, 9, bin BRAM address width.
- `DIV_W`, 4, scroll_div width.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `x` in X_W: video column.
- `y` in Y_W: video row.
- `lower_blank` in 1: high during vertical blanking.
- `scroll_div` in DIV_W: scroll once every scroll_div+1 frames.
- `freeze` in 1: suppress scrolling.
- `dir` in 1: 0 places the newest line at the bottom; 1 places it at the top.
- `bin_rd_en` out 1: bin BRAM read enable.
- `bin_rd_addr` out BIN_ADDR_W: bin BRAM read address.
- `bin_rd_data` in PIX_W: bin BRAM data, returned 1 cycle after the address.
- `fb_addr` out FB_ADDR_W: frame buffer address.
- `fb_we` out 1: frame buffer write enable.
- `fb_wdata` out PIX_W: frame buffer write data.
- `busy` out 1: high in CLEAR and WRITE_LINE.
- `overrun` out 1: 1-cycle pulse when `lower_blank` falls during WRITE_LINE.

## Operation
State machine: CLEAR, VIDEO, WRITE_LINE, WAIT_BLANK_END.

- **CLEAR**
  - Writes 0 to addresses 0..H·V−1 with `fb_we`=1, one per cycle, taking H·V cycles.
  - Then goes to VIDEO.
- **VIDEO**
  - `fb_addr` = rd_base + x, with `fb_we`=0.
  - rd_base is an accumulator, not a multiplier:
    - At x==0, y==0 it loads to offset·H.
    - At each x==0 with y≠0 it adds H.
    - It wraps by subtracting H·V when the sum reaches H·V.
  - On the `lower_blank` rising edge:
    - If frame_cnt==scroll_div and !freeze: clear frame_cnt and enter WRITE_LINE.
    - Otherwise: increment frame_cnt, saturating at scroll_div, and enter WAIT_BLANK_END.
- **WRITE_LINE** lasts H+1 cycles, indexed by i = 0..H.
  - Cycle i: `bin_rd_addr`=i and `bin_rd_en`=1 when i<BINS.
  - Cycle i≥1:
    - `fb_we`=1 and `fb_addr` = wr_base + (i−1).
    - `fb_wdata` = `bin_rd_data` when i−1<BINS, else 0.
  - Row selection:
    - wr row = offset when dir=0.
    - wr row = (offset−1) mod V when dir=1.
  - On exit:
    - dir=0: offset ← (offset+1) mod V.
    - dir=1: offset ← wr row.
  - Then goes to WAIT_BLANK_END.
- **WAIT_BLANK_END**: when `lower_blank`=0, goes to VIDEO.

Mapping and boundary rules:
- Display row y maps to buffer row (offset+y) mod V.
- offset range is 0..V−1 strictly. V−1 wraps to 0, and 0 wraps to V−1.
- A `lower_blank` fall during WRITE_LINE does not abort the write. It pulses `overrun` and exits to VIDEO after the line completes.
- `scroll_div` and `dir` changes are sampled only at the blank rising edge.
- `freeze`=1 still advances frame_cnt up to scroll_div and holds it there.
- `reset` at any cycle:
  - offset=0, frame_cnt=0, i=0, rd_base=0.
  - State becomes CLEAR, or VIDEO without the macro.
  - A pending line write is abandoned.

## Timing
- Reset values of all outputs: `fb_addr`=0, `fb_we`=0, `fb_wdata`=0, `bin_rd_en`=0, `bin_rd_addr`=0, `overrun`=0.
- `busy`=1 in the cycle after reset when `WATERFALL_CLEAR_EN` is defined, else 0.
- All outputs are registered.
- `fb_addr` lags x by 1 cycle. The downstream RAM plus gradient lookup add 2 more cycles; pixel blanking for this is the top level's job.
- A line write takes H+1 cycles. The `lower_blank` window must be ≥ H+2 cycles to avoid `overrun`.
- CLEAR completes H·V cycles after reset deasserts.

## Configuration
- `WATERFALL_CLEAR_EN` defined: reset enters CLEAR, zeroing the whole buffer before the first frame is shown.
- `WATERFALL_CLEAR_EN` undefined:
  - The CLEAR state is removed and reset enters VIDEO directly.
  - Buffer content is undefined until V lines have been written.
  - `busy` is high only in WRITE_LINE.

## Structure
- Package `waterfall_pkg`: state enum, `FB_DEPTH`=H·V constant, and a clog2-based width function.
- Sub-module `ring_row_ptr`, instantiated twice (read and write row bases):
  - Holds a row index mod V and a base address mod H·V.
  - Operations: load, increment and decrement.
  - Uses add/subtract only; no multiplier.

## Test plan
- **Clear:** reset with the macro on and H=8, V=4 → exactly 32 writes of 0 to addresses 0..31, then `busy`=0.
- **Single scroll:** scroll_div=0, dir=0, bins=i+1 → row 0 written with 1..8.
  - Next frame: y=3 reads addresses 0..7.
  - Blank lasting 10 cycles gives no `overrun`.
- **Wrap:** 5 scrolls with dir=0, V=4 → offset sequence 1, 2, 3, 0, 1. dir=1 from 0 → write row 3, offset 3.
- **Rate/freeze:** scroll_div=2 → writes on frames 3, 6, 9. `freeze`=1 → no writes; first blank after release writes immediately.
- **Partial line:** BINS=5, H=8 → columns 5..7 written 0. `lower_blank` falling at i=4 → `overrun` pulse, write still completes.
- **Mid-write reset:** reset at i=3 → `fb_we`=0 next cycle, offset=0, CLEAR restarts at address 0.

Source files
------------

// File: rtl/waterfall_pkg.sv
// Shared types and constants for the scrolling spectrogram frame-buffer controller.
package waterfall_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        VIDEO,
        WRITE_LINE,
        WAIT_BLANK_END
    } state_t;

    localparam int DEFAULT_H = 320;
    localparam int DEFAULT_V = 240;
    localparam int FB_DEPTH  = DEFAULT_H * DEFAULT_V;

    // Bits needed to hold the values 0..depth-1, never less than one.
    function automatic int width_for(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/waterfall_scroller_ring_row_ptr.sv
// Circular row pointer: keeps a row index mod ROWS and its base address mod ROWS*ROW_LEN.
module ring_row_ptr #(
    parameter int ROWS    = 240,
    parameter int ROW_LEN = 320,
    parameter int ROW_W   = 8,
    parameter int ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic              dec,
    input  logic [ROW_W-1:0]  load_row,
    input  logic [ADDR_W-1:0] load_base,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] base_next
);

    localparam int              DEPTH    = ROWS * ROW_LEN;
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_W    = (ADDR_W + 1)'(ROW_LEN);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0] row_next;
    logic [ADDR_W:0]  sum;

    // Wrap by compare-and-subtract so the base never needs a multiplier.
    always_comb begin
        row_next  = row;
        base_next = base;
        sum       = {1'b0, base} + LEN_W;
        if (load) begin
            row_next  = load_row;
            base_next = load_base;
        end else if (inc) begin
            row_next  = (row == LAST_ROW) ? '0 : row + 1'b1;
            base_next = (sum >= DEPTH_W) ? ADDR_W'(sum - DEPTH_W) : ADDR_W'(sum);
        end else if (dec) begin
            row_next  = (row == '0) ? LAST_ROW : row - 1'b1;
            base_next = (base == '0) ? ADDR_W'(DEPTH_W - LEN_W) : base - ADDR_W'(LEN_W);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row  <= '0;
            base <= '0;
        end else begin
            row  <= row_next;
            base <= base_next;
        end
    end

endmodule

// File: rtl/waterfall_scroller.sv
// Scrolling spectrogram frame-buffer controller: circular-offset reads in active video, one line copy per blank.
// Define WATERFALL_CLEAR_EN to zero the whole buffer after reset before the first frame is shown.
import waterfall_pkg::*;

module waterfall_scroller #(
    parameter int H_VISIBLE  = 320,
    parameter int V_VISIBLE  = 240,
    parameter int BINS       = 320,
    parameter int PIX_W      = 8,
    parameter int X_W        = 9,
    parameter int Y_W        = 8,
    parameter int FB_ADDR_W  = 17,
    parameter int BIN_ADDR_W = 9,
    parameter int DIV_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [X_W-1:0]        x,
    input  logic [Y_W-1:0]        y,
    input  logic                  lower_blank,
    input  logic [DIV_W-1:0]      scroll_div,
    input  logic                  freeze,
    input  logic                  dir,
    output logic                  bin_rd_en,
    output logic [BIN_ADDR_W-1:0] bin_rd_addr,
    input  logic [PIX_W-1:0]      bin_rd_data,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic                  fb_we,
    output logic [PIX_W-1:0]      fb_wdata,
    output logic                  busy,
    output logic                  overrun
);

    localparam int             I_W    = width_for(H_VISIBLE + 1);
    localparam logic [I_W-1:0] I_LAST = I_W'(H_VISIBLE);
    localparam logic [I_W-1:0] I_BINS = I_W'(BINS);
`ifdef WATERFALL_CLEAR_EN
    localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
    logic [FB_ADDR_W-1:0] clr_addr;
`endif

    state_t               state;
    logic [I_W-1:0]       idx;
    logic [DIV_W-1:0]     frame_cnt;
    logic                 blank_q;
    logic                 dir_q;
    logic                 blank_rise;
    logic                 blank_fall;
    logic                 start_write;

    logic [Y_W-1:0]       off_row;
    logic [FB_ADDR_W-1:0] off_base;
    logic [FB_ADDR_W-1:0] off_base_next;
    logic [Y_W-1:0]       rd_row;
    logic [FB_ADDR_W-1:0] rd_base;
    logic [FB_ADDR_W-1:0] rd_base_next;
    logic                 unused_ptr;

    assign blank_rise  = lower_blank & ~blank_q;
    assign blank_fall  = ~lower_blank & blank_q;
    assign start_write = (state == VIDEO) && blank_rise && (frame_cnt == scroll_div) && !freeze;
    assign unused_ptr  = ^{rd_row, rd_base, off_base_next};

    // The offset pointer doubles as the write row: dir=1 steps back before the copy, dir=0 steps forward after it.
    ring_row_ptr #(
        .ROWS(V_VISIBLE), .ROW_LEN(H_VISIBLE), .ROW_W(Y_W), .ADDR_W(FB_ADDR_W)
    ) u_wr_ptr (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .inc       ((state == WRITE_LINE) && (idx == I_LAST) && !dir_q),
        .dec       (start_write && dir),
        .load_row  ('0),
        .load_base ('0),
        .row       (off_row),
        .base      (off_base),
        .base_next (off_base_next)
    );

    ring_row_ptr #(
        .ROWS(V_VISIBLE), .ROW_LEN(H_VISIBLE), .ROW_W(Y_W), .ADDR_W(FB_ADDR_W)
    ) u_rd_ptr (
        .clk       (clk),
        .reset     (reset),
        .load      ((state == VIDEO) && (x == '0) && (y == '0)),
        .inc       ((state == VIDEO) && (x == '0) && (y != '0)),
        .dec       (1'b0),
        .load_row  (off_row),
        .load_base (off_base),
        .row       (rd_row),
        .base      (rd_base),
        .base_next (rd_base_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef WATERFALL_CLEAR_EN
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
`else
            state    <= VIDEO;
            busy     <= 1'b0;
`endif
            idx         <= '0;
            frame_cnt   <= '0;
            blank_q     <= 1'b0;
            dir_q       <= 1'b0;
            fb_addr     <= '0;
            fb_we       <= 1'b0;
            fb_wdata    <= '0;
            bin_rd_en   <= 1'b0;
            bin_rd_addr <= '0;
            overrun     <= 1'b0;
        end else begin
            blank_q   <= lower_blank;
            fb_we     <= 1'b0;
            fb_wdata  <= '0;
            bin_rd_en <= 1'b0;
            overrun   <= 1'b0;
            case (state)
`ifdef WATERFALL_CLEAR_EN
                CLEAR: begin
                    fb_we   <= 1'b1;
                    fb_addr <= clr_addr;
                    if (clr_addr == CLR_LAST) begin
                        clr_addr <= '0;
                        busy     <= 1'b0;
                        state    <= VIDEO;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
`endif
                VIDEO: begin
                    fb_addr <= rd_base_next + FB_ADDR_W'(x);
                    if (start_write) begin
                        frame_cnt   <= '0;
                        idx         <= '0;
                        dir_q       <= dir;
                        busy        <= 1'b1;
                        bin_rd_en   <= (BINS > 0);
                        bin_rd_addr <= '0;
                        state       <= WRITE_LINE;
                    end else if (blank_rise) begin
                        frame_cnt <= (frame_cnt < scroll_div) ? frame_cnt + 1'b1 : scroll_div;
                        state     <= WAIT_BLANK_END;
                    end
                end
                // The bin read runs one index ahead of the buffer write to cover the BRAM latency.
                WRITE_LINE: begin
                    overrun <= blank_fall;
                    if (idx != '0) begin
                        fb_we    <= 1'b1;
                        fb_addr  <= off_base + FB_ADDR_W'(idx - 1'b1);
                        fb_wdata <= ((idx - 1'b1) < I_BINS) ? bin_rd_data : '0;
                    end
                    if (idx == I_LAST) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= lower_blank ? WAIT_BLANK_END : VIDEO;
                    end else begin
                        idx         <= idx + 1'b1;
                        bin_rd_en   <= ((idx + 1'b1) < I_BINS);
                        bin_rd_addr <= BIN_ADDR_W'(idx + 1'b1);
                    end
                end
                WAIT_BLANK_END: begin
                    if (!lower_blank) begin
                        state <= VIDEO;
                    end
                end
                default: begin
                    state <= VIDEO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_waterfall_scroller.sv
// Directed bench for waterfall_scroller on an 8x4 buffer with 5 bins; honours WATERFALL_CLEAR_EN.
module tb_waterfall_scroller;

    localparam int H = 8;
    localparam int V = 4;
    localparam logic [63:0] ROW_PAT = 64'h01020304_05000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] x;
    logic [2:0] y;
    logic       lower_blank;
    logic [3:0] scroll_div;
    logic       freeze;
    logic       dir;
    logic       bin_rd_en;
    logic [2:0] bin_rd_addr;
    logic [7:0] bin_rd_data;
    logic [4:0] fb_addr;
    logic       fb_we;
    logic [7:0] fb_wdata;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int burst_n = 0;
    int burst_first = -1;
    int ovr_n = 0;
    int exp_off = 0;
    logic [7:0] fbmem [0:H*V-1];

    waterfall_scroller #(
        .H_VISIBLE(H), .V_VISIBLE(V), .BINS(5), .PIX_W(8), .X_W(4), .Y_W(3),
        .FB_ADDR_W(5), .BIN_ADDR_W(3), .DIV_W(4)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .lower_blank(lower_blank),
        .scroll_div(scroll_div), .freeze(freeze), .dir(dir),
        .bin_rd_en(bin_rd_en), .bin_rd_addr(bin_rd_addr), .bin_rd_data(bin_rd_data),
        .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Bin BRAM model: bin k holds k+1, one cycle of read latency.
    always @(posedge clk) begin
        if (bin_rd_en) bin_rd_data <= 8'(bin_rd_addr) + 8'd1;
    end

    // Frame buffer model and write/overrun monitor.
    always @(negedge clk) begin
        if (fb_we) begin
            if (burst_n == 0) burst_first = int'(fb_addr);
            burst_n++;
            fbmem[fb_addr] = fb_wdata;
        end
        if (overrun) ovr_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic fillFF();
        for (int a = 0; a < H*V; a++) fbmem[a] = 8'hFF;
    endtask

    function automatic logic [63:0] rowWord(input int r);
        logic [63:0] w;
        w = '0;
        for (int c = 0; c < H; c++) w = {w[55:0], fbmem[r*H + c]};
        return w;
    endfunction

    function automatic int zeroCells();
        int n;
        n = 0;
        for (int a = 0; a < H*V; a++) if (fbmem[a] == 8'h00) n++;
        return n;
    endfunction

    // Active video: every pixel's read address must follow the circular row offset.
    task automatic driveFrame(input int rd_off);
        lower_blank = 1'b0;
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                x = 4'(xx);
                y = 3'(yy);
                tick();
                checkOutput("rd_addr", 64'(fb_addr), 64'(((rd_off + yy) % V) * H + xx));
            end
        end
    endtask

    task automatic applyStimulus(input int rd_off, input int blank_len);
        driveFrame(rd_off);
        fillFF();
        burst_n = 0;
        x = 4'd1;
        y = 3'(V);
        lower_blank = 1'b1;
        repeat (blank_len) tick();
        lower_blank = 1'b0;
        repeat (12) tick();
    endtask

    task automatic waitClear();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checkOutput("clear_cycles", 64'(n), 64'(H*V));
        repeat (2) tick();
        checkOutput("clear_writes", 64'(burst_n), 64'(H*V));
        checkOutput("clear_first", 64'(burst_first), 64'd0);
        checkOutput("clear_zero", 64'(zeroCells()), 64'(H*V));
    endtask

    task automatic checkWrite(input string tag, input int row);
        checkOutput({tag, "_cnt"}, 64'(burst_n), 64'(H));
        checkOutput({tag, "_row"}, 64'(burst_first), 64'(row * H));
        checkOutput({tag, "_data"}, rowWord(row), ROW_PAT);
    endtask

    initial begin
        logic [8:0] mask;
        int ovr_before;
        reset = 1'b1;
        x = '0;
        y = '0;
        lower_blank = 1'b0;
        scroll_div = 4'd0;
        freeze = 1'b0;
        dir = 1'b0;
        fillFF();
        repeat (3) tick();
        checkOutput("rst_fb_addr", 64'(fb_addr), 64'd0);
        checkOutput("rst_fb_we", 64'(fb_we), 64'd0);
        checkOutput("rst_fb_wdata", 64'(fb_wdata), 64'd0);
        checkOutput("rst_bin_en", 64'(bin_rd_en), 64'd0);
        checkOutput("rst_bin_addr", 64'(bin_rd_addr), 64'd0);
        checkOutput("rst_overrun", 64'(overrun), 64'd0);
`ifdef WATERFALL_CLEAR_EN
        checkOutput("rst_busy", 64'(busy), 64'd1);
        burst_n = 0;
        reset = 1'b0;
        waitClear();
`else
        checkOutput("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
`endif

        $display("[TB] single scroll and wrap");
        ovr_before = ovr_n;
        applyStimulus(exp_off, 10);
        checkWrite("scroll0", 0);
        checkOutput("no_overrun", 64'(ovr_n - ovr_before), 64'd0);
        exp_off = 1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(exp_off, 10);
            checkWrite("wrap", exp_off);
            exp_off = (exp_off + 1) % V;
        end
        checkOutput("wrap_offset", 64'(exp_off), 64'd1);

        $display("[TB] partial line with overrun");
        ovr_before = ovr_n;
        applyStimulus(exp_off, 4);
        checkOutput("overrun_pulse", 64'(ovr_n - ovr_before), 64'd1);
        checkWrite("overrun", exp_off);
        exp_off = (exp_off + 1) % V;

        $display("[TB] reset during a line write");
        driveFrame(exp_off);
        burst_n = 0;
        x = 4'd1;
        y = 3'(V);
        lower_blank = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        lower_blank = 1'b0;
        tick();
        checkOutput("midrst_we", 64'(fb_we), 64'd0);
        reset = 1'b0;
`ifdef WATERFALL_CLEAR_EN
        checkOutput("midrst_busy", 64'(busy), 64'd1);
        fillFF();
        burst_n = 0;
        waitClear();
`else
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        tick();
`endif
        exp_off = 0;

        $display("[TB] reversed direction");
        dir = 1'b1;
        applyStimulus(exp_off, 10);
        checkWrite("dir1", 3);
        dir = 1'b0;
        exp_off = 3;

        $display("[TB] scroll rate");
        scroll_div = 4'd2;
        mask = '0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(exp_off, 10);
            mask[k] = (burst_n != 0);
            if (k % 3 == 2) exp_off = (exp_off + 1) % V;
        end
        checkOutput("rate_mask", 64'(mask), 64'(9'b100100100));

        $display("[TB] freeze");
        freeze = 1'b1;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(exp_off, 10);
            mask[k] = (burst_n != 0);
        end
        checkOutput("freeze_mask", 64'(mask), 64'd0);
        freeze = 1'b0;
        applyStimulus(exp_off, 10);
        checkWrite("unfreeze", exp_off);
        exp_off = (exp_off + 1) % V;
        driveFrame(exp_off);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
